// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the sequential ALU:
//   - op code constants (OP_AND..OP_REMU)
//   - FSM state encodings
//   - is_iter(): op codes that use the iterative shift core
// Ports: none (package).
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic is_iter(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_shift_core.sv
// alu_shift_core
//   Shared 2*WIDTH accumulator used by MUL (shift-add, LSB first) and
//   DIVU/REMU (restoring division, MSB first). One step per step_i.
//   Layout: MUL {product_hi, multiplier/product_lo}; DIV {remainder, quotient}.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       load accumulator with {0, a_i}
//   step_i       advance one iteration
//   div_i        1: division step, 0: multiply step
//   a_i          operand loaded at load_i
//   b_i          multiplicand / divisor (held stable by the caller)
//   acc_o        current accumulator
//   acc_nxt_o    accumulator after one step (combinational)
module alu_shift_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] acc_nxt_o
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    // Carry out of the high half is kept and shifted back in.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder shifted left with the next dividend bit; an explicit
    // compare (not the subtract borrow) keeps b==0 well defined:
    // quotient becomes all ones and the remainder ends up equal to a.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, b_i};
    if (rem_sh >= {1'b0, b_i}) begin
      div_nxt = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    acc_nxt_o = div_i ? div_nxt : mul_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
    end else if (step_i) begin
      acc_q <= acc_nxt_o;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Multi-cycle ALU with start/busy/done handshake. Logic, ADD, SUB and SLTU
//   finish in one cycle; MUL, DIVU and REMU iterate WIDTH steps in
//   alu_shift_core. Results are registered and held until the next done.
// Ports:
//   clk, rst_n      clock, async active-low reset (deassertion synchronised)
//   start_i         request, accepted only in IDLE
//   op_i            operation code (see alu_pkg)
//   a_i, b_i        operands (dividend / divisor for DIVU/REMU)
//   busy_o          iterative op in flight
//   done_o          result valid pulse
//   result_o        result (MUL: low half)
//   result_hi_o     MUL high half, 0 otherwise
//   zero_o          result_o == 0
//   div0_o          DIVU/REMU with b == 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting; single-cycle ops complete here
// ITER    | one shift-core step per cycle, busy_o high
// FIN     | done_o high for the iterative result, no new op accepted
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             div0_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         rst_sync;
  logic               rst_int_n;
  logic [1:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic               zero_q;
  logic               div0_q;
  logic               done_q;
  logic               op_long;
  logic               core_load;
  logic               core_step;
  logic [WIDTH-1:0]   single_res;
  logic [WIDTH-1:0]   fin_res;
  logic [WIDTH-1:0]   fin_hi;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;

  // Reset asserts immediately, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync[1];

  // With division disabled, DIVU/REMU fall through to the single-cycle path.
  assign op_long   = is_iter(op_i) && ((op_i == OP_MUL) || (DIV_EN != 0));
  assign core_load = (state_q == ST_IDLE) && start_i && op_long;
  assign core_step = (state_q == ST_ITER);

  alu_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .load_i    (core_load),
    .step_i    (core_step),
    .div_i     (op_q != OP_MUL),
    .a_i       (a_i),
    .b_i       (b_q),
    .acc_o     (acc),
    .acc_nxt_o (acc_nxt)
  );

  always_comb begin
    single_res = '0;
    case (op_i)
      OP_AND:  single_res = a_i & b_i;
      OP_OR:   single_res = a_i | b_i;
      OP_ADD:  single_res = a_i + b_i;
      OP_SUB:  single_res = a_i - b_i;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: single_res = '0;
    endcase
  end

  // Final result is taken from the last step's next value so it is
  // registered on the same edge that ends ITER.
  always_comb begin
    fin_res = '0;
    fin_hi  = '0;
    if (op_q == OP_MUL) begin
      fin_res = acc_nxt[WIDTH-1:0];
      fin_hi  = acc_nxt[2*WIDTH-1:WIDTH];
    end else if (op_q == OP_DIVU) begin
      fin_res = acc_nxt[WIDTH-1:0];
    end else begin
      fin_res = acc_nxt[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_AND;
      b_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      div0_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (op_long) begin
              op_q    <= op_i;
              b_q     <= b_i;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= ST_ITER;
            end else begin
              result_q    <= single_res;
              result_hi_q <= '0;
              zero_q      <= (single_res == '0);
              div0_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= ST_FIN;
            result_q    <= fin_res;
            result_hi_q <= fin_hi;
            zero_q      <= (fin_res == '0);
            div0_q      <= (op_q != OP_MUL) && (b_q == '0);
            done_q      <= 1'b1;
          end
        end
        ST_FIN: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == ST_ITER);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign zero_o      = zero_q;
  assign div0_o      = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Bench for alu_seq: one 32-bit instance with division, one 8-bit
//   instance with DIV_EN=0. Expected values come from plain arithmetic.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;

  logic        busy32, done32, zero32, div032;
  logic [31:0] res32, hi32;
  logic        busy8, done8, zero8, div08;
  logic [7:0]  res8, hi8;

  int checks = 0;
  int errors = 0;

  logic [2:0] sops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .DIV_EN(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(start32), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy32), .done_o(done32),
    .result_o(res32), .result_hi_o(hi32), .zero_o(zero32), .div0_o(div032)
  );

  alu_seq #(.WIDTH(8), .DIV_EN(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .op_i(op_i),
    .a_i(a_i[7:0]), .b_i(b_i[7:0]), .busy_o(busy8), .done_o(done8),
    .result_o(res8), .result_hi_o(hi8), .zero_o(zero8), .div0_o(div08)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] g_res(input bit w8);
    return w8 ? {56'b0, res8} : {32'b0, res32};
  endfunction
  function automatic logic [63:0] g_hi(input bit w8);
    return w8 ? {56'b0, hi8} : {32'b0, hi32};
  endfunction

  // Reference model: result, high half, div0 flag and latency in cycles.
  task automatic model(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [63:0] res,
                       output logic [63:0] hi, output logic d0, output int lat);
    longint unsigned m, aa, bb, p;
    int w;
    w   = w8 ? 8 : 32;
    m   = (64'd1 << w) - 1;
    aa  = a & m;
    bb  = b & m;
    res = 0; hi = 0; d0 = 1'b0; lat = 1;
    case (op)
      3'd0: res = aa & bb;
      3'd1: res = aa | bb;
      3'd2: res = (aa + bb) & m;
      3'd4: res = (aa - bb) & m;
      3'd6: res = (aa < bb) ? 1 : 0;
      3'd5: begin
        p = aa * bb;
        res = p & m;
        hi = (p >> w) & m;
        lat = w + 1;
      end
      default: begin
        if (!w8) begin
          lat = w + 1;
          d0 = (bb == 0);
          if (bb == 0) res = (op == 3'd3) ? m : aa;
          else res = (op == 3'd3) ? aa / bb : aa % bb;
        end
      end
    endcase
  endtask

  task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] e_res, e_hi;
    logic e_d0;
    int e_lat, n, nb;
    bit got;
    model(w8, op, a, b, e_res, e_hi, e_d0, e_lat);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; start32 = 1'b0;
    op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (w8 ? busy8 : busy32) nb++;
      if (w8 ? done8 : done32) got = 1'b1;
    end
    chk($sformatf("latency op%0d w8=%0d", op, w8), 64'(n), 64'(e_lat));
    chk($sformatf("busy_cycles op%0d", op), 64'(nb), 64'(e_lat - 1));
    chk($sformatf("result op%0d a=%0h b=%0h", op, a, b), g_res(w8), e_res);
    chk($sformatf("result_hi op%0d", op), g_hi(w8), e_hi);
    chk($sformatf("zero op%0d", op), 64'(w8 ? zero8 : zero32), 64'(e_res == 0));
    chk($sformatf("div0 op%0d", op), 64'(w8 ? div08 : div032), 64'(e_d0));
  endtask

  initial begin
    logic [63:0] er, eh, cap_r, cap_h;
    logic ed;
    int el, nd;
    logic [2:0] op;
    logic [31:0] a, b;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy32), 0);
    chk("rst_done", 64'(done32), 0);
    chk("rst_result", g_res(0), 0);
    chk("rst_hi", g_hi(0), 0);
    chk("rst_zero", 64'(zero32), 1);
    chk("rst_div0", 64'(div032), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd1);
    run_op(0, 3'd4, 32'd5, 32'd7);
    run_op(0, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(0, 3'd3, 32'd100, 32'd7);
    run_op(0, 3'd7, 32'd100, 32'd7);
    run_op(0, 3'd3, 32'd9, 32'd0);
    run_op(0, 3'd7, 32'd9, 32'd0);
    run_op(0, 3'd6, 32'd3, 32'd3);

    // Back-to-back single-cycle ops: done stays high, results follow.
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      op = sops[$urandom_range(0, 4)];
      a = $urandom; b = $urandom;
      model(0, op, a, b, er, eh, ed, el);
      op_i = op; a_i = a; b_i = b; start32 = 1'b1;
      @(negedge clk);
      chk("b2b_done", 64'(done32), 1);
      chk("b2b_result", g_res(0), er);
    end
    start32 = 1'b0;
    @(negedge clk);
    chk("b2b_done_drop", 64'(done32), 0);

    // Start during ITER and during FIN must both be ignored.
    model(0, 3'd5, 32'h1234_5678, 32'h9ABC_DEF0, er, eh, ed, el);
    @(negedge clk);
    op_i = 3'd5; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    nd = 0; cap_r = 0; cap_h = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start32 = 1'b0;
      if (k == 4) begin
        op_i = 3'd2; a_i = 32'd1; b_i = 32'd2; start32 = 1'b1;
      end
      if (done32) begin
        nd++;
        if (nd == 1) begin
          cap_r = g_res(0); cap_h = g_hi(0);
          op_i = 3'd2; a_i = 32'd7; b_i = 32'd8; start32 = 1'b1;
        end
      end
    end
    start32 = 1'b0;
    chk("ignore_done_count", 64'(nd), 1);
    chk("ignore_mul_lo", cap_r, er);
    chk("ignore_mul_hi", cap_h, eh);
    chk("ignore_held", g_res(0), er);

    // Reset in the middle of a DIVU.
    @(negedge clk);
    op_i = 3'd3; a_i = 32'd1000; b_i = 32'd3; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", 64'(busy32), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy32), 0);
    chk("mid_rst_result", g_res(0), 0);
    chk("mid_rst_hi", g_hi(0), 0);
    chk("mid_rst_zero", 64'(zero32), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done32 || busy32) nd++;
    end
    chk("mid_rst_no_done", 64'(nd), 0);
    run_op(0, 3'd2, 32'd40, 32'd2);

    // 8-bit instance without division.
    run_op(1, 3'd6, 32'd3, 32'd200);
    run_op(1, 3'd3, 32'd50, 32'd7);
    run_op(1, 3'd7, 32'd50, 32'd0);
    run_op(1, 3'd5, 32'h10, 32'h10);

    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(0, op, a, b);
    end
    for (int k = 0; k < 15; k++) begin
      run_op(1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
